// File: rtl/dpram_burst_reader.sv
// dpram_burst_reader: read-side master for a 16x8 dual-port RAM.
// Fetches a burst of consecutive words from the RAM read port and streams
// them out over a valid/ready interface at up to one word per cycle.
module dpram_burst_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [ADDR_W:0]   burst_len_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              m_last_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    // Word count is one bit wider than the address so a full-depth burst fits.
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] CNT_TWO   = (ADDR_W + 1)'(2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SEND
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic                m_valid_q, m_valid_d;
    logic                m_last_q, m_last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                handshake;
    logic                len_zero;
    logic [ADDR_W:0]     len_sat;

    assign handshake = m_valid_q && m_ready_i;
    assign len_zero  = (burst_len_i == '0);
    assign len_sat   = (burst_len_i > DEPTH_CNT) ? DEPTH_CNT : burst_len_i;

    // State and datapath registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            mem_addr_q  <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            mem_addr_q  <= mem_addr_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic: IDLE -> FETCH on a non-empty request, one FETCH
    // cycle to prime the output register, then SEND until the last handshake.
    always_comb begin
        // NOTE: a default assignment ahead of the case keeps every path
        // assigned, so no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i && !len_zero) state_d = S_FETCH;
            S_FETCH: state_d = S_SEND;
            S_SEND:  if (handshake && m_last_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values: registers hold unless the state acts on them;
    // done is a single-cycle pulse so it defaults low.
    always_comb begin
        remaining_d = remaining_q;
        mem_addr_d  = mem_addr_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (len_zero) begin
                        done_d = 1'b1;
                    end else begin
                        remaining_d = len_sat;
                        mem_addr_d  = start_addr_i;
                        busy_d      = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                m_data_d   = mem_rdata_i;
                m_valid_d  = 1'b1;
                m_last_d   = (remaining_q == CNT_ONE);
                mem_addr_d = mem_addr_q + 1'b1;
            end
            S_SEND: begin
                if (handshake) begin
                    if (m_last_q) begin
                        remaining_d = '0;
                        m_valid_d   = 1'b0;
                        m_last_d    = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        // Address wraps modulo DEPTH through natural overflow.
                        m_data_d    = mem_rdata_i;
                        remaining_d = remaining_q - 1'b1;
                        m_last_d    = (remaining_q == CNT_TWO);
                        mem_addr_d  = mem_addr_q + 1'b1;
                    end
                end
            end
            default: begin
                remaining_d = '0;
            end
        endcase
    end

    assign mem_addr_o = mem_addr_q;
    assign m_data_o   = m_data_q;
    assign m_valid_o  = m_valid_q;
    assign m_last_o   = m_last_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_dpram_burst_reader.sv
// Testbench for dpram_burst_reader: RAM modelled as an array with a
// combinational read port; expected streams are built from the RAM contents
// and the burst rules (saturation, modulo addressing, one word per handshake).
module tb_dpram_burst_reader;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [3:0] start_addr_i;
    logic [4:0] burst_len_i;
    logic [3:0] mem_addr_o;
    logic [7:0] mem_rdata_i;
    logic [7:0] m_data_o;
    logic       m_valid_o;
    logic       m_ready_i;
    logic       m_last_o;
    logic       busy_o;
    logic       done_o;

    logic [7:0] ram [16];
    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    dpram_burst_reader #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .start_addr_i (start_addr_i),
        .burst_len_i  (burst_len_i),
        .mem_addr_o   (mem_addr_o),
        .mem_rdata_i  (mem_rdata_i),
        .m_data_o     (m_data_o),
        .m_valid_o    (m_valid_o),
        .m_ready_i    (m_ready_i),
        .m_last_o     (m_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    assign mem_rdata_i = ram[mem_addr_o];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ram_ramp();
        for (int i = 0; i < 16; i++) ram[i] = 8'hA0 + 8'(i);
    endtask

    task automatic check_idle_quiet(input string tag);
        check({tag, "_valid"}, m_valid_o, 1'b0);
        check({tag, "_busy"},  busy_o,    1'b0);
        check({tag, "_done"},  done_o,    1'b0);
    endtask

    // Run one burst request and check the whole stream against the model.
    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic run_burst(input logic [3:0] sa, input logic [4:0] len,
                             input int pct, input int stall_first, input bit poke);
        logic [7:0] exp_w [16];
        int         n;
        int         idx = 0;
        int         cyc = 0;
        int         stalls = 0;
        bit         prev_hs = 0;
        bit         prev_stall = 0;
        logic [7:0] held_d = '0;
        logic       held_l = 1'b0;

        n = (int'(len) > 16) ? 16 : int'(len);
        for (int k = 0; k < n; k++) exp_w[k] = ram[(int'(sa) + k) % 16];

        start_i      = 1'b1;
        start_addr_i = sa;
        burst_len_i  = len;
        m_ready_i    = 1'b0;
        @(negedge clk);
        start_i      = 1'b0;
        start_addr_i = 4'($urandom_range(0, 15));
        burst_len_i  = 5'($urandom_range(1, 31));

        if (n == 0) begin
            check("noop_done",  done_o,    1'b1);
            check("noop_busy",  busy_o,    1'b0);
            check("noop_valid", m_valid_o, 1'b0);
            for (int j = 0; j < 2; j++) begin
                @(negedge clk);
                check_idle_quiet("noop_after");
            end
            return;
        end

        check("fetch_busy",  busy_o,     1'b1);
        check("fetch_valid", m_valid_o,  1'b0);
        check("fetch_addr",  mem_addr_o, 32'(sa));
        if (poke) begin
            start_i      = 1'b1;
            start_addr_i = sa + 4'd7;
            burst_len_i  = 5'd9;
        end

        while (idx < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start_i = 1'b0;
            if (cyc == 1 || prev_hs) check("stream_valid", m_valid_o, 1'b1);
            check("no_early_done", done_o, 1'b0);
            prev_hs = 0;
            if (m_valid_o) begin
                check("mem_addr", mem_addr_o, 32'((int'(sa) + idx + 1) % 16));
                if (prev_stall) begin
                    check("hold_data", m_data_o, held_d);
                    check("hold_last", m_last_o, held_l);
                end
                if (idx == 0 && stalls < stall_first) begin
                    m_ready_i = 1'b0;
                    stalls++;
                end else begin
                    m_ready_i = (int'($urandom_range(0, 99)) < pct);
                end
                if (m_ready_i) begin
                    check("data", m_data_o, exp_w[idx]);
                    check("last", m_last_o, (idx == n - 1));
                    idx++;
                    prev_hs    = 1;
                    prev_stall = 0;
                end else begin
                    prev_stall = 1;
                    held_d     = m_data_o;
                    held_l     = m_last_o;
                end
            end else begin
                m_ready_i = 1'($urandom_range(0, 1));
            end
        end
        if (idx < n) check("burst_timeout", 32'(idx), 32'(n));

        @(negedge clk);
        m_ready_i = 1'b0;
        check("end_done",  done_o,    1'b1);
        check("end_busy",  busy_o,    1'b0);
        check("end_valid", m_valid_o, 1'b0);
        check("end_last",  m_last_o,  1'b0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);

        // Reset held two cycles with start asserted.
        rst_i        = 1'b1;
        start_i      = 1'b1;
        start_addr_i = 4'd3;
        burst_len_i  = 5'd4;
        m_ready_i    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_mem_addr", mem_addr_o, 4'd0);
        check("rst_data",     m_data_o,   8'd0);
        check("rst_last",     m_last_o,   1'b0);
        check_idle_quiet("rst");
        rst_i   = 1'b0;
        start_i = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check_idle_quiet("post_rst");
        end

        ram_ramp();
        run_burst(4'd2, 5'd3, 100, 0, 0);    // A2,A3,A4
        @(negedge clk);
        check_idle_quiet("done_single");
        run_burst(4'd14, 5'd4, 100, 0, 0);   // wrap AE,AF,A0,A1
        run_burst(4'd0, 5'd2, 100, 3, 0);    // backpressure on first word
        @(negedge clk);
        check_idle_quiet("bp_after");
        run_burst(4'd6, 5'd0, 100, 0, 0);    // no-op
        run_burst(4'd9, 5'd20, 100, 0, 0);   // saturates to 16
        run_burst(4'd3, 5'd5, 100, 0, 1);    // start while busy ignored
        run_burst(4'd15, 5'd16, 70, 1, 1);   // next start in the done cycle

        // Reset mid-burst after two words accepted.
        @(negedge clk);
        start_i      = 1'b1;
        start_addr_i = 4'd0;
        burst_len_i  = 5'd5;
        m_ready_i    = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        check("mid_w0", m_data_o, 8'hA0);
        @(negedge clk);
        check("mid_w1", m_data_o, 8'hA1);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i     = 1'b0;
        m_ready_i = 1'b0;
        check("mid_rst_addr", mem_addr_o, 4'd0);
        check("mid_rst_data", m_data_o,   8'd0);
        check_idle_quiet("mid_rst");
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check_idle_quiet("mid_rst_after");
        end

        // Port-A writes: captured word stays, unfetched word picks up new value.
        start_i      = 1'b1;
        start_addr_i = 4'd5;
        burst_len_i  = 5'd2;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        check("pa_first", m_data_o, 8'hA5);
        ram[5] = 8'h11;
        ram[6] = 8'h22;
        @(negedge clk);
        check("pa_held", m_data_o, 8'hA5);
        m_ready_i = 1'b1;
        @(negedge clk);
        check("pa_new",  m_data_o, 8'h22);
        check("pa_last", m_last_o, 1'b1);
        @(negedge clk);
        m_ready_i = 1'b0;
        check("pa_done", done_o, 1'b1);

        // Randomized bursts against the reference model.
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
            run_burst(4'($urandom_range(0, 15)), 5'($urandom_range(0, 20)),
                      int'($urandom_range(40, 100)), int'($urandom_range(0, 2)),
                      1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                check_idle_quiet("rand_gap");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
